majority_vote_sampler: RTL and testbench
========================================

MAJORITY_VOTE_SAMPLER -- requirements
Module: MajorityVoteSampler

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the completed-window counter.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port clear, input, 1: synchronous abort of the current window.
REQ-005 SHALL have port in_val, input, 1: upstream sample valid.
REQ-006 SHALL have port in_rdy, output, 1: block accepts a sample this cycle.
REQ-007 SHALL have port in_bit, input, 1: serial sample.
REQ-008 SHALL have port out_val, output, 1: window result valid.
REQ-009 SHALL have port out_rdy, input, 1: downstream accepts the result.
REQ-010 SHALL have port out_samples, output, 3: captured window; bit0 is the first sample, bit2 the third.
REQ-011 SHALL have port out_vote, output, 1: 1 when at least two of out_samples are 1.
REQ-012 SHALL have port out_ones, output, 2: population count of out_samples, range 0..3.
REQ-013 SHALL have port win_count, output, CNT_W: number of results consumed downstream.

Function
REQ-014 SHALL implement FSM states S0, S1, S2 (collecting sample 0/1/2) and EMIT.
REQ-015 SHALL drive in_rdy=1 in S0/S1/S2 and in_rdy=0 in EMIT.
REQ-016 SHALL accept a sample only when in_val && in_rdy, writing it to sample bit k in state Sk and advancing S0->S1->S2->EMIT.
REQ-017 SHALL hold its state and sample bits when in_val=0 in a collect state.
REQ-018 SHALL drive out_val=1 only in EMIT, one cycle after the third sample is accepted.
REQ-019 SHALL hold out_samples, out_vote and out_ones stable while out_val=1 and out_rdy=0.
REQ-020 SHALL, on out_val && out_rdy, return to S0 and increment win_count by 1, modulo 2^CNT_W (all-ones wraps to 0).
REQ-021 SHALL NOT accept an input sample in the cycle a result is consumed; minimum window period is 4 cycles.
REQ-022 SHALL compute out_vote and out_ones combinationally from the registered sample bits.
REQ-023 SHALL, when clear=1, go to S0 on the next edge, discard the partial or pending window, leave win_count unchanged and ignore any coincident handshake.
REQ-024 SHALL give rst_n priority over clear, and clear priority over both handshakes.
REQ-025 SHALL drive out_vote, out_ones and out_samples as don't-care when out_val=0, though they SHALL remain deterministic.

Reset
REQ-026 SHALL, when rst_n=0 at a rising edge, set state=S0, sample bits=000 and win_count=0.
REQ-027 SHALL force in_rdy=0 and out_val=0 combinationally while rst_n=0.
REQ-028 SHALL discard any window in progress when rst_n is asserted mid-operation, including in EMIT; no result is emitted.
REQ-029 SHALL, after rst_n deasserts, drive in_rdy=1, out_val=0, out_samples=000, out_vote=0 and out_ones=0.

Structure
REQ-030 SHALL place state encodings S0=2'd0, S1=2'd1, S2=2'd2 and EMIT=2'd3 in the shared package as localparams.
REQ-031 SHALL compute out_vote with one instance of the team's gate-level PairTripleDetector fed by sample bits 0, 1 and 2.
REQ-032 SHALL compute out_ones in the top-level module; no other sub-modules.

Verification
REQ-033 Bench SHALL drive bits 1,0,1 with in_val held high and out_rdy=1 -> out_val high exactly one cycle after the third accept, out_samples=101, out_vote=1, out_ones=2, win_count=1 the next cycle.
REQ-034 Bench SHALL drive bits 0,0,1 with in_val gaps of 2 idle cycles between samples -> out_samples=100, out_vote=0, out_ones=1, with no out_val during the gaps.
REQ-035 Bench SHALL drive bits 1,1,1 with out_rdy held low 5 cycles -> out_val and out_samples=111 stable 5 cycles, in_rdy=0 throughout, win_count increments once on release.
REQ-036 Bench SHALL accept two samples then assert clear -> state S0, no out_val; the next three samples 0,1,1 give out_vote=1 and win_count unchanged by the clear.
REQ-037 Bench SHALL set CNT_W=2 and consume 5 windows -> win_count sequence 1,2,3,0,1.
REQ-038 Bench SHALL assert rst_n=0 during EMIT with out_rdy=1 in the same cycle -> no increment, win_count=0, out_val=0 and in_rdy=0 during reset, in_rdy=1 after deassert.

Source files
------------

// File: rtl/majority_vote_sampler_pkg.sv
// Shared definitions for the majority-vote sampler: FSM encodings and state type.
// Each window collects three serial samples and then emits one result.
package majority_vote_sampler_pkg;

  localparam logic [1:0] S0   = 2'd0;
  localparam logic [1:0] S1   = 2'd1;
  localparam logic [1:0] S2   = 2'd2;
  localparam logic [1:0] EMIT = 2'd3;

  typedef enum logic [1:0] {
    ST_S0   = S0,
    ST_S1   = S1,
    ST_S2   = S2,
    ST_EMIT = EMIT
  } state_t;

  localparam int WINDOW_LEN = 3;

endpackage

// File: rtl/majority_vote_sampler_pair_triple_detector.sv
// Gate-level 2-of-3 detector: pair is high when at least two inputs are high.
module pair_triple_detector (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic pair
);

  logic ab;
  logic bc;
  logic ac;

  and g_ab (ab, a, b);
  and g_bc (bc, b, c);
  and g_ac (ac, a, c);
  or  g_pair (pair, ab, bc, ac);

endmodule

// File: rtl/majority_vote_sampler.sv
// Collects three serial samples per window, presents them with a majority vote
// and a ones count, and counts the windows consumed downstream.
module majority_vote_sampler
  import majority_vote_sampler_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_bit,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [2:0]       out_samples,
  output logic             out_vote,
  output logic [1:0]       out_ones,
  output logic [CNT_W-1:0] win_count
);

  state_t           state;
  logic [2:0]       samples;
  logic [CNT_W-1:0] count;

  // Reset gates the handshakes combinationally so nothing is offered while held.
  assign in_rdy  = rst_n && (state != ST_EMIT);
  assign out_val = rst_n && (state == ST_EMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_S0;
      samples <= 3'b000;
      count   <= '0;
    end else if (clear) begin
      state   <= ST_S0;
      samples <= 3'b000;
    end else begin
      unique case (state)
        ST_S0: begin
          if (in_val) begin
            samples[0] <= in_bit;
            state      <= ST_S1;
          end
        end
        ST_S1: begin
          if (in_val) begin
            samples[1] <= in_bit;
            state      <= ST_S2;
          end
        end
        ST_S2: begin
          if (in_val) begin
            samples[2] <= in_bit;
            state      <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          // Consuming a result takes a full cycle, so no sample is taken here.
          if (out_rdy) begin
            state <= ST_S0;
            count <= count + 1'b1;
          end
        end
        default: state <= ST_S0;
      endcase
    end
  end

  assign out_samples = samples;
  assign win_count   = count;
  assign out_ones    = {1'b0, samples[0]} + {1'b0, samples[1]} + {1'b0, samples[2]};

  pair_triple_detector u_vote (
    .a    (samples[0]),
    .b    (samples[1]),
    .c    (samples[2]),
    .pair (out_vote)
  );

endmodule

// File: tb/tb_majority_vote_sampler.sv
// Self-checking bench: a window-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations and random traffic.
module tb_majority_vote_sampler;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_val = 1'b0;
  logic             in_bit = 1'b0;
  logic             out_rdy = 1'b0;
  logic             in_rdy;
  logic             out_val;
  logic [2:0]       out_samples;
  logic             out_vote;
  logic [1:0]       out_ones;
  logic [CNT_W-1:0] win_count;

  int n_compared = 0;
  int n_mismatch = 0;
  bit chk_en = 1'b0;

  // Reference model: how many samples the current window holds, what they are,
  // and how many results have been handed downstream.
  int         mdl_ncol = 0;
  logic [2:0] mdl_samples = 3'b000;
  int         mdl_count = 0;

  majority_vote_sampler #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_val      (in_val),
    .in_rdy      (in_rdy),
    .in_bit      (in_bit),
    .out_val     (out_val),
    .out_rdy     (out_rdy),
    .out_samples (out_samples),
    .out_vote    (out_vote),
    .out_ones    (out_ones),
    .win_count   (win_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_ncol    <= 0;
      mdl_samples <= 3'b000;
      mdl_count   <= 0;
    end else if (clear) begin
      mdl_ncol    <= 0;
      mdl_samples <= 3'b000;
    end else if (mdl_ncol == 3) begin
      if (out_rdy) begin
        mdl_ncol  <= 0;
        mdl_count <= (mdl_count + 1) % (1 << CNT_W);
      end
    end else if (in_val) begin
      mdl_samples[mdl_ncol] <= in_bit;
      mdl_ncol              <= mdl_ncol + 1;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_val;
      int   ones;
      exp_val = rst_n && (mdl_ncol == 3);
      ones    = mdl_samples[0] + mdl_samples[1] + mdl_samples[2];
      check_output("mdl_in_rdy", 32'(in_rdy), 32'(rst_n && (mdl_ncol != 3)));
      check_output("mdl_out_val", 32'(out_val), 32'(exp_val));
      check_output("mdl_win_count", 32'(win_count), 32'(mdl_count));
      if (exp_val) begin
        check_output("mdl_samples", 32'(out_samples), 32'(mdl_samples));
        check_output("mdl_ones", 32'(out_ones), 32'(ones));
        check_output("mdl_vote", 32'(out_vote), 32'(ones >= 2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic b, input logic r);
    in_val  = v;
    in_bit  = b;
    out_rdy = r;
    tick();
  endtask

  initial begin
    int seq [5] = '{1, 2, 3, 0, 1};
    logic [2:0] bits3;

    // Reset state
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check_output("rst_in_rdy", 32'(in_rdy), 32'd0);
    check_output("rst_out_val", 32'(out_val), 32'd0);
    check_output("rst_count", 32'(win_count), 32'd0);
    rst_n = 1'b1;
    #1;
    check_output("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    check_output("post_rst_samples", 32'(out_samples), 32'd0);
    check_output("post_rst_vote", 32'(out_vote), 32'd0);
    check_output("post_rst_ones", 32'(out_ones), 32'd0);

    // Back-to-back 1,0,1
    apply_stimulus(1'b1, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    check_output("b2b_no_early_val", 32'(out_val), 32'd0);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("b2b_out_val", 32'(out_val), 32'd1);
    check_output("b2b_samples", 32'(out_samples), 32'b101);
    check_output("b2b_vote", 32'(out_vote), 32'd1);
    check_output("b2b_ones", 32'(out_ones), 32'd2);
    check_output("b2b_in_rdy", 32'(in_rdy), 32'd0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("b2b_count", 32'(win_count), 32'd1);
    check_output("b2b_val_drop", 32'(out_val), 32'd0);

    // 0,0,1 with two idle cycles between samples
    bits3 = 3'b100;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, bits3[i], 1'b1);
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          apply_stimulus(1'b0, 1'b0, 1'b1);
          check_output("gap_no_val", 32'(out_val), 32'd0);
        end
      end
    end
    check_output("gap_samples", 32'(out_samples), 32'b100);
    check_output("gap_vote", 32'(out_vote), 32'd0);
    check_output("gap_ones", 32'(out_ones), 32'd1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("gap_count", 32'(win_count), 32'd2);

    // 1,1,1 with downstream stalled for five cycles
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check_output("stall_val", 32'(out_val), 32'd1);
      check_output("stall_samples", 32'(out_samples), 32'b111);
      check_output("stall_in_rdy", 32'(in_rdy), 32'd0);
      check_output("stall_count", 32'(win_count), 32'd2);
      apply_stimulus(1'b1, 1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("stall_release_count", 32'(win_count), 32'd3);

    // Clear after two samples, then a fresh 0,1,1 window
    apply_stimulus(1'b1, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    clear = 1'b1;
    apply_stimulus(1'b1, 1'b1, 1'b1);
    clear = 1'b0;
    check_output("clr_out_val", 32'(out_val), 32'd0);
    check_output("clr_in_rdy", 32'(in_rdy), 32'd1);
    check_output("clr_count", 32'(win_count), 32'd3);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    check_output("clr_win_samples", 32'(out_samples), 32'b110);
    check_output("clr_win_vote", 32'(out_vote), 32'd1);
    check_output("clr_win_count", 32'(win_count), 32'd3);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("clr_wrap_count", 32'(win_count), 32'd0);

    // Counter wrap sequence from reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      check_output("wrap_seq", 32'(win_count), 32'(seq[w]));
    end

    // Reset during EMIT with out_rdy high
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'b0);
    rst_n   = 1'b0;
    out_rdy = 1'b1;
    in_val  = 1'b0;
    #1;
    check_output("emit_rst_in_rdy", 32'(in_rdy), 32'd0);
    check_output("emit_rst_out_val", 32'(out_val), 32'd0);
    tick();
    check_output("emit_rst_count", 32'(win_count), 32'd0);
    check_output("emit_rst_held_val", 32'(out_val), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check_output("emit_rst_after_rdy", 32'(in_rdy), 32'd1);
    check_output("emit_rst_after_val", 32'(out_val), 32'd0);
    check_output("emit_rst_after_samples", 32'(out_samples), 32'd0);
    check_output("emit_rst_after_ones", 32'(out_ones), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      clear = ($urandom_range(0, 39) == 0);
      apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) < 7));
    end
    rst_n = 1'b1;
    clear = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
